// File: rtl/dma_mc_pkg.sv
// ============================================================
// dma_mc_pkg : shared state encoding and default widths
// rev 1.0
// ============================================================
`default_nettype none

package dma_mc_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARB  = 3'd1,
        RD   = 3'd2,
        CAP  = 3'd3,
        WR   = 3'd4
    } state_t;

    localparam int DEF_DATA_W = 10;
    localparam int DEF_ADDR_W = 14;
    localparam int DEF_CH_N   = 4;
    localparam int DEF_LEN_W  = 8;

    // A single channel still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dma_mc_rr_arbiter.sv
// ============================================================
// rr_arbiter : combinational round-robin pick after last_grant
// rev 1.0
// ============================================================
`default_nettype none

module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    int               w_j;
    logic [IDX_W-1:0] w_pos;
    logic             w_found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_j       = 0;
        w_pos     = '0;
        for (int k = 1; k <= N; k++) begin
            w_j = int'(last_grant) + k;
            if (w_j >= N) begin
                w_j = w_j - N;
            end
            w_pos = IDX_W'(w_j);
            if (!w_found && req[w_pos]) begin
                w_found      = 1'b1;
                grant[w_pos] = 1'b1;
                grant_idx    = w_pos;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dma_mc.sv
// ============================================================
// dma_mc : multi-channel word-interleaved DMA, CPU has priority
// rev 1.0
// ============================================================
`default_nettype none

module dma_mc
    import dma_mc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CH_N   = DEF_CH_N,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CH_N-1:0]      ch_start,
    input  logic [CH_N*ADDR_W-1:0] ch_src,
    input  logic [CH_N*ADDR_W-1:0] ch_dst,
    input  logic [CH_N*LEN_W-1:0]  ch_len,
    input  logic [CH_N-1:0]      ch_fixsrc,
    output logic [CH_N-1:0]      ch_busy,
    output logic [CH_N-1:0]      ch_done,
    input  logic                 cpu_req,
    output logic                 cpu_grant,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic                 ram_read,
    output logic                 ram_write,
    output logic [DATA_W-1:0]    ram_wdata,
    input  logic [DATA_W-1:0]    ram_rdata
);

    localparam int IDX_W = idx_width(CH_N);

    state_t            r_state, w_next;
    logic [IDX_W-1:0]  r_sel, r_last, w_arb_idx;
    logic [CH_N-1:0]   r_sel_oh, w_arb_oh, w_busy, w_zdone, w_wr_en, w_fin, w_remain;
    logic [DATA_W-1:0] r_buf;
    logic              r_grant;
    logic              w_last_word;
    logic [ADDR_W-1:0] w_src [CH_N];
    logic [ADDR_W-1:0] w_dst [CH_N];
    logic [LEN_W-1:0]  w_len [CH_N];

    assign w_wr_en     = (r_state == WR) ? r_sel_oh : '0;
    assign w_last_word = (w_len[r_sel] == LEN_W'(1));
    assign w_fin       = w_last_word ? w_wr_en : '0;
    assign w_remain    = w_busy & ~w_fin;

    for (genvar i = 0; i < CH_N; i++) begin : g_ch
        logic [ADDR_W-1:0] r_src, r_dst;
        logic [LEN_W-1:0]  r_len;
        logic              r_fix, r_busy, r_zdone;
        logic [LEN_W-1:0]  w_len_in;
        logic              w_start_ok;

        assign w_len_in   = ch_len[i*LEN_W +: LEN_W];
        assign w_start_ok = ch_start[i] && !r_busy && (w_len_in != '0);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_src   <= '0;
                r_dst   <= '0;
                r_len   <= '0;
                r_fix   <= 1'b0;
                r_busy  <= 1'b0;
                r_zdone <= 1'b0;
            end else begin
                // A zero-length start completes immediately without ever going busy.
                r_zdone <= ch_start[i] && !r_busy && (w_len_in == '0);
                if (w_start_ok) begin
                    r_src  <= ch_src[i*ADDR_W +: ADDR_W];
                    r_dst  <= ch_dst[i*ADDR_W +: ADDR_W];
                    r_len  <= w_len_in;
                    r_fix  <= ch_fixsrc[i];
                    r_busy <= 1'b1;
                end else if (w_wr_en[i]) begin
                    r_dst <= r_dst + ADDR_W'(1);
                    if (!r_fix) begin
                        r_src <= r_src + ADDR_W'(1);
                    end
                    r_len <= r_len - LEN_W'(1);
                    if (r_len == LEN_W'(1)) begin
                        r_busy <= 1'b0;
                    end
                end
            end
        end

        assign w_src[i]   = r_src;
        assign w_dst[i]   = r_dst;
        assign w_len[i]   = r_len;
        assign w_busy[i]  = r_busy;
        assign w_zdone[i] = r_zdone;
    end

    rr_arbiter #(
        .N     (CH_N),
        .IDX_W (IDX_W)
    ) u_arb (
        .req        (w_busy),
        .last_grant (r_last),
        .grant      (w_arb_oh),
        .grant_idx  (w_arb_idx)
    );

    always_comb begin
        w_next    = r_state;
        ram_read  = 1'b0;
        ram_write = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (r_state)
            IDLE: if (!cpu_req && (|w_busy)) w_next = ARB;
            ARB:  w_next = cpu_req ? IDLE : RD;
            RD: begin
                ram_read = 1'b1;
                ram_addr = w_src[r_sel];
                w_next   = CAP;
            end
            CAP:  w_next = WR;
            WR: begin
                ram_write = 1'b1;
                ram_addr  = w_dst[r_sel];
                ram_wdata = r_buf;
                w_next    = (|w_remain) ? ARB : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_sel    <= '0;
            r_sel_oh <= '0;
            r_last   <= IDX_W'(CH_N - 1);
            r_buf    <= '0;
            r_grant  <= 1'b0;
        end else begin
            r_state <= w_next;
            // Grant tracks the IDLE state so it can never overlap a RAM strobe.
            r_grant <= (w_next == IDLE) && cpu_req;
            if ((r_state == ARB) && !cpu_req) begin
                r_sel    <= w_arb_idx;
                r_sel_oh <= w_arb_oh;
            end
            if (r_state == CAP) begin
                r_buf <= ram_rdata;
            end
            if (r_state == WR) begin
                r_last <= r_sel;
            end
        end
    end

    assign cpu_grant = r_grant;
    assign ch_busy   = w_busy;
    assign ch_done   = w_zdone | w_fin;

endmodule

`default_nettype wire
